// File: rtl/hazard_scoreboard.sv
// Issue-side scoreboard: per-register countdowns for loads and MUL/DIV results, stalling ID on RAW/WAW/unit-busy.
// Optional stall-cycle counter is built only when SB_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic [1:0]          issue_kind_i,
    input  logic [4:0]          issue_rd_i,
    input  logic [4:0]          issue_rs1_i,
    input  logic [4:0]          issue_rs2_i,
    input  logic                issue_use_rs1_i,
    input  logic                issue_use_rs2_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                mul_busy_o,
    output logic [31:0]         stall_cycles_o
);
    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;
    localparam logic [1:0] K_NONE = 2'b11;

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] mul_cnt;
    logic [CNT_W-1:0] new_lat;
    logic             raw1, raw2, waw, strct, accept;

    always_comb begin
        new_lat = '0;
        if (issue_rd_i != 5'd0) begin
            case (issue_kind_i)
                K_LOAD:  new_lat = CNT_W'(LOAD_LAT);
                K_MUL:   new_lat = CNT_W'(MUL_LAT);
                default: new_lat = '0;
            endcase
        end
    end

    assign raw1   = issue_use_rs1_i && (issue_rs1_i != 5'd0) && (cnt[issue_rs1_i] != '0);
    assign raw2   = issue_use_rs2_i && (issue_rs2_i != 5'd0) && (cnt[issue_rs2_i] != '0);
    // A later short-latency write must not retire ahead of an older long one.
    assign waw    = (issue_kind_i != K_NONE) && (issue_rd_i != 5'd0) && (cnt[issue_rd_i] > new_lat);
    assign strct  = (issue_kind_i == K_MUL) && (mul_cnt != '0);
    assign stall_o = issue_valid_i && (raw1 || raw2 || waw || strct);
    assign accept  = issue_valid_i && !stall_o && !flush_i;

    // cnt[0] is only ever reset, so x0 never reads as pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (accept && (new_lat != '0) && (issue_rd_i == 5'(r)))
                    cnt[r] <= new_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            mul_cnt <= '0;
        else if (accept && (issue_kind_i == K_MUL))
            mul_cnt <= CNT_W'(MUL_LAT);
        else if (mul_cnt != '0)
            mul_cnt <= mul_cnt - 1'b1;
    end

    always_comb begin
        pending_o = '0;
        for (int r = 1; r < NUM_REGS; r++) pending_o[r] = (cnt[r] != '0);
    end

    assign mul_busy_o = (mul_cnt != '0);

`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt <= '0;
        else if (stall_o)
            stall_cnt <= stall_cnt + 32'd1;
    end
    assign stall_cycles_o = stall_cnt;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard; each row is one cycle of issue inputs plus expected outputs.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        v, u1, u2, fl;
    logic [1:0]  k;
    logic [4:0]  rd, rs1, rs2;
    logic        stall, busy;
    logic [31:0] pend, perf;

    int n_cmp  = 0;
    int n_fail = 0;
    int perf_exp = 0;

`ifdef SB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(v), .issue_kind_i(k),
        .issue_rd_i(rd), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
        .issue_use_rs1_i(u1), .issue_use_rs2_i(u2), .flush_i(fl),
        .stall_o(stall), .pending_o(pend), .mul_busy_o(busy), .stall_cycles_o(perf)
    );

    typedef struct packed {
        logic        v;
        logic [1:0]  k;
        logic [4:0]  rd, rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2, fl;
        logic        st;
        logic [31:0] pend;
        logic        busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic v_, logic [1:0] k_, logic [4:0] rd_, logic [4:0] rs1_, logic u1_,
                                logic [4:0] rs2_, logic u2_, logic fl_, logic st_, logic [31:0] p_, logic b_);
        vec_t r;
        r.v = v_; r.k = k_; r.rd = rd_; r.rs1 = rs1_; r.u1 = u1_; r.rs2 = rs2_; r.u2 = u2_; r.fl = fl_;
        r.st = st_; r.pend = p_; r.busy = b_;
        return r;
    endfunction

    function automatic logic [31:0] b(int n);
        return 32'd1 << n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        v = r.v; k = r.k; rd = r.rd; rs1 = r.rs1; u1 = r.u1; rs2 = r.rs2; u2 = r.u2; fl = r.fl;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tv[i].st});
            chk($sformatf("row%0d pending", i), pend, tv[i].pend);
            chk($sformatf("row%0d mul_busy", i), {31'd0, busy}, {31'd0, tv[i].busy});
            chk($sformatf("row%0d stall_cycles", i), perf, PERF ? 32'(perf_exp) : 32'd0);
            if (tv[i].st) perf_exp++;
        end
    endtask

    initial begin
        //            v  k     rd  rs1 u1 rs2 u2 fl  st pend    busy
        // load x5 then dependent ALU: one stall
        tv.push_back(mk(1, 2'b01, 5,  0, 0, 0, 0, 0,  0, 0,      0)); // 0
        tv.push_back(mk(1, 2'b00, 6,  5, 1, 0, 0, 0,  1, b(5),   0));
        tv.push_back(mk(1, 2'b00, 6,  5, 1, 0, 0, 0,  0, 0,      0));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, 0,      0));
        // MUL x7 then consumer on rs2: three stalls
        tv.push_back(mk(1, 2'b10, 7,  0, 0, 0, 0, 0,  0, 0,      0)); // 4
        tv.push_back(mk(1, 2'b00, 8,  0, 0, 7, 1, 0,  1, b(7),   1));
        tv.push_back(mk(1, 2'b00, 8,  0, 0, 7, 1, 0,  1, b(7),   1));
        tv.push_back(mk(1, 2'b00, 8,  0, 0, 7, 1, 0,  1, b(7),   1));
        tv.push_back(mk(1, 2'b00, 8,  0, 0, 7, 1, 0,  0, 0,      0));
        // load to x0 is never tracked
        tv.push_back(mk(1, 2'b01, 0,  0, 0, 0, 0, 0,  0, 0,      0)); // 9
        tv.push_back(mk(1, 2'b00, 1,  0, 1, 0, 1, 0,  0, 0,      0));
        // MUL x9 then ALU write x9: WAW until cnt drains
        tv.push_back(mk(1, 2'b10, 9,  0, 0, 0, 0, 0,  0, 0,      0)); // 11
        tv.push_back(mk(1, 2'b00, 9,  0, 0, 0, 0, 0,  1, b(9),   1));
        tv.push_back(mk(1, 2'b00, 9,  0, 0, 0, 0, 0,  1, b(9),   1));
        tv.push_back(mk(1, 2'b00, 9,  0, 0, 0, 0, 0,  1, b(9),   1));
        tv.push_back(mk(1, 2'b00, 9,  0, 0, 0, 0, 0,  0, 0,      0));
        // MUL x10 then load x10: WAW only while cnt > LOAD_LAT; load then overrides
        tv.push_back(mk(1, 2'b10, 10, 0, 0, 0, 0, 0,  0, 0,      0)); // 16
        tv.push_back(mk(1, 2'b01, 10, 0, 0, 0, 0, 0,  1, b(10),  1));
        tv.push_back(mk(1, 2'b01, 10, 0, 0, 0, 0, 0,  1, b(10),  1));
        tv.push_back(mk(1, 2'b01, 10, 0, 0, 0, 0, 0,  0, b(10),  1));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, b(10),  0));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, 0,      0));
        // back-to-back MULs: structural stall
        tv.push_back(mk(1, 2'b10, 11, 0, 0, 0, 0, 0,  0, 0,      0)); // 22
        tv.push_back(mk(1, 2'b10, 12, 0, 0, 0, 0, 0,  1, b(11),  1));
        tv.push_back(mk(1, 2'b10, 12, 0, 0, 0, 0, 0,  1, b(11),  1));
        tv.push_back(mk(1, 2'b10, 12, 0, 0, 0, 0, 0,  1, b(11),  1));
        tv.push_back(mk(1, 2'b10, 12, 0, 0, 0, 0, 0,  0, 0,      0));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, b(12),  1));
        // flushed load sets nothing
        tv.push_back(mk(1, 2'b01, 13, 0, 0, 0, 0, 1,  0, b(12),  1)); // 28
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, b(12),  1));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, 0,      0));
        // flush does not mask stall
        tv.push_back(mk(1, 2'b01, 14, 0, 0, 0, 0, 0,  0, 0,      0)); // 31
        tv.push_back(mk(1, 2'b00, 15, 14,1, 0, 0, 1,  1, b(14),  0));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, 0,      0));
        // kind 11 with nonzero rd never tracks
        tv.push_back(mk(1, 2'b11, 15, 0, 0, 0, 0, 0,  0, 0,      0)); // 34
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, 0,      0));
        // after reset: 1 load stall + 3 MUL stalls = 4
        tv.push_back(mk(1, 2'b01, 4,  0, 0, 0, 0, 0,  0, 0,      0)); // 36
        tv.push_back(mk(1, 2'b00, 5,  4, 1, 0, 0, 0,  1, b(4),   0));
        tv.push_back(mk(1, 2'b00, 5,  4, 1, 0, 0, 0,  0, 0,      0));
        tv.push_back(mk(1, 2'b10, 3,  0, 0, 0, 0, 0,  0, 0,      0));
        tv.push_back(mk(1, 2'b00, 6,  0, 0, 3, 1, 0,  1, b(3),   1));
        tv.push_back(mk(1, 2'b00, 6,  0, 0, 3, 1, 0,  1, b(3),   1));
        tv.push_back(mk(1, 2'b00, 6,  0, 0, 3, 1, 0,  1, b(3),   1));
        tv.push_back(mk(1, 2'b00, 6,  0, 0, 3, 1, 0,  0, 0,      0));
        tv.push_back(mk(0, 2'b00, 0,  0, 0, 0, 0, 0,  0, 0,      0)); // 44: perf == 4

        rst = 1'b1;
        drive(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset pending", pend, 32'd0);
        chk("reset mul_busy", {31'd0, busy}, 32'd0);
        chk("reset stall_cycles", perf, 32'd0);
        rst = 1'b0;

        run_rows(0, 35);

        // reset in the shadow of a MUL clears everything immediately
        @(negedge clk);
        drive(mk(1, 2'b10, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 2'b00, 8, 7, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("shadow stall", {31'd0, stall}, 32'd1);
        chk("shadow mul_busy", {31'd0, busy}, 32'd1);
        chk("shadow pending", pend, b(7));
        #2 rst = 1'b1;
        #1;
        chk("midrst stall", {31'd0, stall}, 32'd0);
        chk("midrst pending", pend, 32'd0);
        chk("midrst mul_busy", {31'd0, busy}, 32'd0);
        chk("midrst stall_cycles", perf, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        perf_exp = 0;

        run_rows(36, 44);
        chk("final stall_cycles", perf, PERF ? 32'd4 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-side companion to the forwarding logic.
- Tracks in-flight destination registers whose results cannot be forwarded in time: loads, and results from the multi-cycle MUL/DIV unit.
- Raises a stall to the IF/ID stage on RAW, WAW and multi-cycle-unit structural hazards.
- Sits between ID decode and the ID/EXE pipeline register; the forwarding logic resolves all remaining ALU-to-ALU dependencies.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- LOAD_LAT, 1, cycles a dependent instruction must wait after a load issues.
- MUL_LAT, 3, cycles a dependent instruction must wait after a MUL/DIV issues; also the unit occupancy.
- CNT_W, 2, per-register countdown width; must hold max(LOAD_LAT, MUL_LAT).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- issue_valid_i  input  1  the ID stage presents an instruction.
- issue_kind_i  input  2  00 ALU (latency 0), 01 load (LOAD_LAT), 10 MUL/DIV (MUL_LAT), 11 no register write.
- issue_rd_i  input  5  destination register.
- issue_rs1_i  input  5  source 1.
- issue_rs2_i  input  5  source 2.
- issue_use_rs1_i  input  1  source 1 is read.
- issue_use_rs2_i  input  1  source 2 is read.
- flush_i  input  1  branch flush; the current issue is discarded.
- stall_o  output  1  hold IF/ID and insert a bubble into ID/EXE.
- pending_o  output  NUM_REGS  bit r = cnt[r] != 0; bit 0 is always 0.
- mul_busy_o  output  1  the MUL/DIV unit is occupied.
- stall_cycles_o  output  32  stall-cycle count (see Optional Feature).

Behaviour:
State:
- cnt[1..NUM_REGS-1], CNT_W bits each.
- mul_cnt, CNT_W bits.
- Reset (asynchronous): all counters 0; hence pending_o = 0 and mul_busy_o = 0. stall_o is 0 whenever issue_valid_i = 0.

Definitions:
- new_lat = 0 / LOAD_LAT / MUL_LAT for kind 00 / 01 / 10.
- new_lat = 0 for kind 11, or when rd = 0.

stall_o (combinational) = issue_valid_i AND (raw1 OR raw2 OR waw OR struct), where:
- raw1 = use_rs1 AND rs1 != 0 AND cnt[rs1] != 0.
- raw2: same rule for rs2.
- waw = kind != 11 AND rd != 0 AND cnt[rd] > new_lat. This keeps writeback ordered.
- struct = kind = 10 AND mul_cnt != 0.
- flush_i does not mask stall_o.

accept = issue_valid_i AND NOT stall_o AND NOT flush_i.

Each rising edge:
- Every nonzero cnt[r] decrements by 1.
- Every nonzero mul_cnt decrements by 1.
- Then, if accept and new_lat != 0: cnt[rd] <= new_lat. The write overrides the decrement for that register.
- If accept and kind = 10: mul_cnt <= MUL_LAT.

Resulting timing:
- Load at cycle T, consumer at T+1: exactly 1 stall cycle (LOAD_LAT = 1).
- MUL at T, consumer at T+1: 3 stall cycles; consumer accepted at T+4.

Boundary rules:
- ALU issue (new_lat = 0) never sets a counter.
- Counters saturate at 0 and never wrap.
- Reset mid-operation clears all tracking immediately, with no residual stall.
- A flushed or stalled issue does not modify any state.

Optional Feature:
- Macro: SB_PERF_CNT_EN.
- Defined: stall_cycles_o is a 32-bit counter.
  - Reset to 0.
  - Increments on every cycle with stall_o = 1.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: stall_cycles_o is tied to 0 and no counter register is built.

Test Plan:
- Load to x5 at T, ALU at T+1 reading rs1 = x5 -> stall_o = 1 for one cycle; accept at T+2; pending_o[5] high during T+1 only.
- MUL to x7, then consumer of x7 -> stall_o high for exactly 3 cycles; mul_busy_o high for 3 cycles.
- Load with rd = x0, then consumer of x0 -> no stall; pending_o stays 0.
- MUL to x9, then ALU writing x9 with no source use -> WAW stall until cnt[9] = 0.
- Back-to-back MULs -> second stalled 3 cycles (struct).
- Mid-MUL shadow, rst_i = 1 -> all outputs 0 immediately.
- With SB_PERF_CNT_EN defined, 4 stall cycles -> stall_cycles_o = 4.
- flush_i = 1 with a load issue -> no pending bit set.
